// File: rtl/hacd_pkg.sv
// Shared Hawk types, sizing constants and helpers.
package hacd_pkg;

   localparam int unsigned HAWK_NUM_WR_CLIENTS     = 2;
   localparam int unsigned HAWK_WR_MAX_OUTSTANDING = 4;

   typedef enum logic {
      ARB   = 1'b0,
      GRANT = 1'b1
   } hawk_wr_arb_state_t;

   // Ceiling log2, never less than 1 so it can size a vector directly.
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      if (res == 0) res = 1;
      return res;
   endfunction

endpackage

// File: rtl/hawk_wr_gnt_fifo.sv
// Small synchronous FIFO of grant indices, one entry per AW awaiting its B.
module hawk_wr_gnt_fifo
   import hacd_pkg::*;
#(
   parameter int unsigned DEPTH = HAWK_WR_MAX_OUTSTANDING,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned PTR_W = clogb2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
         if (do_pop)  rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/hawk_wr_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 write master among NUM_REQ clients.
module hawk_wr_arbiter
   import hacd_pkg::*;
#(
   parameter int unsigned NUM_REQ         = HAWK_NUM_WR_CLIENTS,
   parameter int unsigned ADDR_W          = 64,
   parameter int unsigned DATA_W          = 512,
   parameter int unsigned MAX_OUTSTANDING = HAWK_WR_MAX_OUTSTANDING
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NUM_REQ-1:0]                req_i,
   output logic [NUM_REQ-1:0]                gnt_o,
   input  logic [NUM_REQ-1:0]                c_awvalid_i,
   input  logic [NUM_REQ*ADDR_W-1:0]         c_awaddr_i,
   output logic [NUM_REQ-1:0]                c_awready_o,
   input  logic [NUM_REQ-1:0]                c_wvalid_i,
   input  logic [NUM_REQ*DATA_W-1:0]         c_wdata_i,
   input  logic [NUM_REQ*(DATA_W/8)-1:0]     c_wstrb_i,
   output logic [NUM_REQ-1:0]                c_wready_o,
   output logic [NUM_REQ-1:0]                c_bvalid_o,
   output logic [1:0]                        c_bresp_o,
   output logic                              m_awvalid_o,
   output logic [ADDR_W-1:0]                 m_awaddr_o,
   input  logic                              m_awready_i,
   output logic                              m_wvalid_o,
   output logic [DATA_W-1:0]                 m_wdata_o,
   output logic [DATA_W/8-1:0]               m_wstrb_o,
   input  logic                              m_wready_i,
   input  logic                              m_bvalid_i,
   input  logic [1:0]                        m_bresp_i,
   output logic                              m_bready_o,
   output logic                              busy_o,
   output logic                              err_o
);

   localparam int unsigned IDX_W  = clogb2(NUM_REQ);
   localparam int unsigned STRB_W = DATA_W / 8;

   hawk_wr_arb_state_t state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic               aw_done_q, aw_done_d;
   logic               w_done_q, w_done_d;
   logic               err_q, err_d;

   logic               aw_hs;
   logic               w_hs;
   logic               found;
   logic [IDX_W-1:0]   pick;
   int unsigned        cand;

   logic               fifo_full;
   logic               fifo_empty;
   logic [IDX_W-1:0]   fifo_head;

   // Outstanding-write order, so each B goes back to the client that issued the AW.
   hawk_wr_gnt_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDX_W)
   ) u_gnt_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (aw_hs),
      .din_i   (gidx_q),
      .pop_i   (m_bvalid_i & ~fifo_empty),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   // Payload always follows the granted client; valids gate its meaning.
   assign m_awaddr_o = c_awaddr_i[gidx_q*ADDR_W +: ADDR_W];
   assign m_wdata_o  = c_wdata_i[gidx_q*DATA_W +: DATA_W];
   assign m_wstrb_o  = c_wstrb_i[gidx_q*STRB_W +: STRB_W];

   // A B with nothing outstanding is never accepted, only flagged.
   assign m_bready_o = ~fifo_empty;
   assign c_bvalid_o = (m_bvalid_i & ~fifo_empty) ? (NUM_REQ'(1) << fifo_head) : '0;
   assign c_bresp_o  = m_bresp_i;

   assign gnt_o  = gnt_q;
   assign err_o  = err_q;
   assign busy_o = (state_q == GRANT) | ~fifo_empty;

   // Next-state, grant selection and AW/W channel steering.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gidx_d      = gidx_q;
      rr_d        = rr_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      err_d       = err_q | (m_bvalid_i & fifo_empty);
      m_awvalid_o = 1'b0;
      m_wvalid_o  = 1'b0;
      c_awready_o = '0;
      c_wready_o  = '0;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      found       = 1'b0;
      pick        = '0;
      cand        = 0;

      case (state_q)
         ARB: begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               cand = 32'(rr_q) + i;
               if (cand >= NUM_REQ) cand = cand - NUM_REQ;
               if (!found && req_i[cand]) begin
                  found = 1'b1;
                  pick  = IDX_W'(cand);
               end
            end
            if (found && !fifo_full) begin
               state_d = GRANT;
               gnt_d   = NUM_REQ'(1) << pick;
               gidx_d  = pick;
            end
         end

         GRANT: begin
            m_awvalid_o         = c_awvalid_i[gidx_q] & ~aw_done_q;
            m_wvalid_o          = c_wvalid_i[gidx_q] & ~w_done_q;
            c_awready_o[gidx_q] = m_awready_i & ~aw_done_q;
            c_wready_o[gidx_q]  = m_wready_i & ~w_done_q;
            aw_hs               = c_awvalid_i[gidx_q] & ~aw_done_q & m_awready_i;
            w_hs                = c_wvalid_i[gidx_q] & ~w_done_q & m_wready_i;
            aw_done_d           = aw_done_q | aw_hs;
            w_done_d            = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               state_d   = ARB;
               gnt_d     = '0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rr_d      = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
            end
         end

         default: state_d = ARB;
      endcase
   end

   // State and sticky-flag registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ARB;
         gnt_q     <= '0;
         gidx_q    <= '0;
         rr_q      <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gidx_q    <= gidx_d;
         rr_q      <= rr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
      end
   end

endmodule
